cmos_dvp_capture: RTL and testbench
===================================

// Module: cmos_dvp_capture
// PURPOSE
//  Downstream of the OV5640 register-config stage. Waits for reg_conf_done, then drops the first
//  SKIP_FRAMES frames while AEC/AWB settle. Afterwards it packs the 8-bit DVP byte stream
//  (RGB565, high byte first, per reg 0x4300=0x60) into 16-bit pixels with x/y coordinates,
//  frame/line markers and a geometry-error pulse for the frame-buffer writer.
// PARAMETERS
//  H_ACTIVE     640  pixels per line expected (DVPHO)
//  V_ACTIVE     480  lines per frame expected (DVPVO)
//  SKIP_FRAMES  10   frames discarded after reg_conf_done (range 0..255)
// PORTS
//  cmos_pclk      in   1   camera pixel clock; all logic on rising edge
//  camera_rst     in   1   synchronous reset, active-high
//  reg_conf_done  in   1   level from config stage; 1 = sensor configured
//  cmos_vsync     in   1   DVP VSYNC; high during vertical blanking, rising edge = frame boundary
//  cmos_href      in   1   DVP HREF; high while line bytes are valid
//  cmos_data      in   8   DVP data byte
//  pix_data       out  16  packed RGB565 pixel {byte0, byte1}
//  pix_valid      out  1   pix_data/x_cnt/y_cnt valid this cycle
//  x_cnt          out  11  column of current pixel, saturates at 2047
//  y_cnt          out  10  line of current pixel, saturates at 1023
//  frame_start    out  1   1-cycle pulse coincident with first pix_valid of a frame (x=0,y=0)
//  line_end       out  1   1-cycle pulse after last byte of a line
//  frame_end      out  1   1-cycle pulse at vsync rise closing a captured frame
//  frame_err      out  1   1-cycle pulse: line or frame geometry mismatch
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high (camera_rst), single clock domain (cmos_pclk).
//  Reset values: all outputs 0, state IDLE, skip counter 0, byte phase 0.
//  Input stage: vsync/href/data registered once (vs_r, hr_r, d_r); edges are detected on the registered copies.
//  FSM:
//   IDLE   -> SKIP when reg_conf_done=1 (SKIP_FRAMES=0: straight to ARM).
//   SKIP   -> count vs_r rising edges; on edge number SKIP_FRAMES -> ARM.
//   ARM    -> ACTIVE on the next vs_r falling edge, so capture starts only on a whole frame.
//   ACTIVE -> byte packing enabled; stays in ACTIVE across frames.
//   Any state -> IDLE when reg_conf_done=0. Flush: phase 0, counters 0, no pulses, pix_valid 0 next cycle.
//  Packing (ACTIVE only):
//   - While hr_r=1, phase toggles every cycle. Phase 0 stores d_r as the high byte.
//   - Phase 1 sets pix_data<={hi,d_r} and pix_valid<=1.
//   - Latency: second byte at pins on edge N -> pix_valid high after edge N+2.
//   - hr_r=0 clears phase; a dangling odd byte is discarded and flagged.
//  Counters:
//   - x_cnt = pixel index within the line.
//   - y_cnt = index of lines containing >=1 pixel.
//   - Both reset at a vs_r rising edge. x_cnt resets at an hr_r falling edge.
//   - Both saturate, never wrap.
//  line_end: the cycle after an hr_r falling edge, if the line produced >=1 pixel or an odd byte.
//  frame_err on line_end when: pixel count != H_ACTIVE, or an odd byte remained.
//  frame_end: on a vs_r rising edge in ACTIVE with >=1 line captured.
//  frame_err on frame_end when: line count != V_ACTIVE.
//  Simultaneous events:
//   - An hr_r fall and a vs_r rise in the same cycle: line_end, frame_end and one frame_err may all assert together.
//   - Only one frame_err pulse is issued per cycle.
//  vs_r rising while hr_r=1 (truncated line): the line is closed as if hr_r fell, then frame_end asserts.
// TESTING
//  T1 reset: camera_rst=1 for 3 clocks mid-line -> all outputs 0, FSM IDLE; no pix_valid until reg_conf_done re-qualified.
//  T2 skip: SKIP_FRAMES=2, 4 frames of 640x480 -> frames 1-2 produce no pix_valid; frame 3 gives 307200 pix_valid.
//     Also in T2: frame_start at x=0,y=0; frame_end once per frame; frame_err never.
//  T3 packing: line bytes A1,B2,C3,D4 -> pix_data 16'hA1B2 then 16'hC3D4; x_cnt 0,1.
//     Also in T3: pix_valid 2 clocks after B2/D4 at pins.
//  T4 geometry: line of 639 pixels -> frame_err with that line_end; frame of 479 lines -> frame_err with frame_end.
//     Also in T4: line of 1281 bytes (odd) -> frame_err; the last byte is dropped.
//  T5 config drop: reg_conf_done 1->0 mid-frame -> pix_valid 0 next cycle, counters 0.
//     Also in T5: when reasserted, SKIP restarts from 0.
//  T6 truncation: vsync rises while href=1 at x=100 -> line_end, frame_err and frame_end all in the same cycle.

Source files
------------

// File: rtl/cmos_dvp_capture.sv
// Purpose: OV5640 DVP capture front end. After the sensor is configured it discards the first
// SKIP_FRAMES frames, arms on the next whole frame, then packs the RGB565 byte stream (high byte
// first) into 16-bit pixels with x/y coordinates, frame/line markers and a geometry-error pulse.
//
// Ports:
//   cmos_pclk      camera pixel clock, all logic on its rising edge
//   camera_rst     synchronous active-high reset
//   reg_conf_done  level from the config stage; low flushes the capture back to idle
//   cmos_vsync     DVP VSYNC, rising edge = frame boundary
//   cmos_href      DVP HREF, high while line bytes are valid
//   cmos_data      DVP data byte
//   pix_data       packed pixel {first byte, second byte}
//   pix_valid      pix_data/x_cnt/y_cnt valid this cycle
//   x_cnt, y_cnt   pixel column / line index, both saturating
//   frame_start    with the first pixel of a frame
//   line_end       cycle after a line closes, if it carried any bytes
//   frame_end      at the vsync rise closing a captured frame
//   frame_err      line or frame geometry mismatch (at most one pulse per cycle)
module cmos_dvp_capture #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned SKIP_FRAMES = 10
) (
  input  logic        cmos_pclk,
  input  logic        camera_rst,
  input  logic        reg_conf_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [10:0] x_cnt,
  output logic [9:0]  y_cnt,
  output logic        frame_start,
  output logic        line_end,
  output logic        frame_end,
  output logic        frame_err
);

  typedef enum logic [1:0] {StIdle, StSkip, StArm, StActive} state_e;

  localparam logic [11:0] HAct  = 12'(H_ACTIVE);
  localparam logic [10:0] VAct  = 11'(V_ACTIVE);
  localparam logic [8:0]  SkipN = 9'(SKIP_FRAMES);
  // Internal counters hold "items so far" and stop one past the largest reportable index.
  localparam logic [11:0] XcMax = 12'd2048;
  localparam logic [10:0] LcMax = 11'd1024;

  state_e      state_q, state_d;
  logic        vs_q, vs_d, hr_q, hr_d, vs_prev_q, vs_prev_d, hr_prev_q, hr_prev_d;
  logic [7:0]  d_q, d_d;
  logic [7:0]  skip_q, skip_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [11:0] xc_q, xc_d;
  logic [10:0] lc_q, lc_d;
  logic        trunc_q, trunc_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic [10:0] x_cnt_q, x_cnt_d;
  logic [9:0]  y_cnt_q, y_cnt_d;
  logic        fs_q, fs_d, le_q, le_d, fe_q, fe_d, err_q, err_d;

  logic        vs_rise, vs_fall, hr_fall, line_close;
  logic [10:0] lines_tot;

  assign vs_rise    = vs_q & ~vs_prev_q;
  assign vs_fall    = ~vs_q & vs_prev_q;
  assign hr_fall    = ~hr_q & hr_prev_q;
  // A vsync rise during an active line closes that line as if href had dropped.
  assign line_close = hr_fall | (vs_rise & hr_q);

  always_comb begin
    vs_d        = cmos_vsync;
    hr_d        = cmos_href;
    d_d         = cmos_data;
    vs_prev_d   = vs_q;
    hr_prev_d   = hr_q;
    state_d     = state_q;
    skip_d      = skip_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    xc_d        = xc_q;
    lc_d        = lc_q;
    trunc_d     = trunc_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    fs_d        = 1'b0;
    le_d        = 1'b0;
    fe_d        = 1'b0;
    err_d       = 1'b0;
    lines_tot   = lc_q;

    if (!reg_conf_done) begin
      state_d = StIdle;
      skip_d  = '0;
      phase_d = 1'b0;
      xc_d    = '0;
      lc_d    = '0;
      trunc_d = 1'b0;
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          skip_d  = '0;
          state_d = (SkipN == 9'd0) ? StArm : StSkip;
        end
        StSkip: begin
          if (vs_rise) begin
            if ({1'b0, skip_q} + 9'd1 == SkipN) begin
              state_d = StArm;
              skip_d  = '0;
            end else begin
              skip_d = skip_q + 8'd1;
            end
          end
        end
        StArm: begin
          // Wait for the end of vertical blanking so capture begins on a whole frame.
          if (vs_fall) state_d = StActive;
        end
        StActive: begin
          if (line_close) begin
            phase_d = 1'b0;
            xc_d    = '0;
            if ((xc_q != '0) || phase_q) begin
              le_d = 1'b1;
              if ((xc_q != HAct) || phase_q) err_d = 1'b1;
            end
            if ((xc_q != '0) && (lc_q != LcMax)) lines_tot = lc_q + 11'd1;
            lc_d = lines_tot;
          end
          if (vs_rise) begin
            if (lines_tot != '0) begin
              fe_d = 1'b1;
              if (lines_tot != VAct) err_d = 1'b1;
            end
            lc_d    = '0;
            xc_d    = '0;
            phase_d = 1'b0;
            // Ignore the rest of a truncated line until href drops.
            trunc_d = hr_q;
          end else if (hr_q && !trunc_q) begin
            if (!phase_q) begin
              hi_d    = d_q;
              phase_d = 1'b1;
            end else begin
              phase_d     = 1'b0;
              pix_valid_d = 1'b1;
              pix_data_d  = {hi_q, d_q};
              x_cnt_d     = xc_q[11] ? 11'h7ff : xc_q[10:0];
              y_cnt_d     = lc_q[10] ? 10'h3ff : lc_q[9:0];
              fs_d        = (xc_q == '0) && (lc_q == '0);
              if (xc_q != XcMax) xc_d = xc_q + 12'd1;
            end
          end
          if (!hr_q) trunc_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge cmos_pclk) begin
    if (camera_rst) begin
      state_q     <= StIdle;
      vs_q        <= 1'b0;
      hr_q        <= 1'b0;
      d_q         <= '0;
      vs_prev_q   <= 1'b0;
      hr_prev_q   <= 1'b0;
      skip_q      <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      xc_q        <= '0;
      lc_q        <= '0;
      trunc_q     <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      fs_q        <= 1'b0;
      le_q        <= 1'b0;
      fe_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_q        <= vs_d;
      hr_q        <= hr_d;
      d_q         <= d_d;
      vs_prev_q   <= vs_prev_d;
      hr_prev_q   <= hr_prev_d;
      skip_q      <= skip_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      xc_q        <= xc_d;
      lc_q        <= lc_d;
      trunc_q     <= trunc_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      fs_q        <= fs_d;
      le_q        <= le_d;
      fe_q        <= fe_d;
      err_q       <= err_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign x_cnt       = x_cnt_q;
  assign y_cnt       = y_cnt_q;
  assign frame_start = fs_q;
  assign line_end    = le_q;
  assign frame_end   = fe_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// Bench for cmos_dvp_capture with a reduced geometry (8x4 pixels, 2 skipped frames).
// A frame-level model predicts every output each cycle; directed literal checks pin
// latency, packing, skip counts, geometry errors, flush, truncation and saturation.
module tb_cmos_dvp_capture;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int SKIP = 2;
  localparam int MIdle = 0, MSkip = 1, MArm = 2, MAct = 3;

  logic        cmos_pclk = 1'b0;
  logic        camera_rst, reg_conf_done, cmos_vsync, cmos_href;
  logic [7:0]  cmos_data;
  logic [15:0] pix_data;
  logic        pix_valid, frame_start, line_end, frame_end, frame_err;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;

  cmos_dvp_capture #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .SKIP_FRAMES(SKIP)
  ) dut (
    .cmos_pclk    (cmos_pclk),
    .camera_rst   (camera_rst),
    .reg_conf_done(reg_conf_done),
    .cmos_vsync   (cmos_vsync),
    .cmos_href    (cmos_href),
    .cmos_data    (cmos_data),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .x_cnt        (x_cnt),
    .y_cnt        (y_cnt),
    .frame_start  (frame_start),
    .line_end     (line_end),
    .frame_end    (frame_end),
    .frame_err    (frame_err)
  );

  always #5 cmos_pclk = ~cmos_pclk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: frames, lines and byte counts ----------------
  bit        model_live = 1'b0;
  bit        m_vs1, m_hr1, m_vs2, m_hr2;
  bit [7:0]  m_d1, m_hi;
  int        mode, skipped, lbytes, lines;
  bit        trunc;
  bit        e_pv, e_fs, e_le, e_fe, e_err;
  bit [15:0] e_pd;
  int        e_x, e_y;

  task automatic model_step();
    bit vs, hr, rise, fall, hfall;
    int px;
    bit odd;
    if (camera_rst) begin
      m_vs1 = 0; m_hr1 = 0; m_vs2 = 0; m_hr2 = 0; m_d1 = 0;
      mode = MIdle; skipped = 0; lbytes = 0; lines = 0; trunc = 0;
      e_pv = 0; e_fs = 0; e_le = 0; e_fe = 0; e_err = 0; e_x = 0; e_y = 0;
    end else begin
      vs = m_vs1; hr = m_hr1;
      rise = vs && !m_vs2; fall = !vs && m_vs2; hfall = !hr && m_hr2;
      e_pv = 0; e_fs = 0; e_le = 0; e_fe = 0; e_err = 0;
      if (!reg_conf_done) begin
        mode = MIdle; skipped = 0; lbytes = 0; lines = 0; trunc = 0; e_x = 0; e_y = 0;
      end else if (mode == MIdle) begin
        mode = (SKIP == 0) ? MArm : MSkip;
      end else if (mode == MSkip) begin
        if (rise) begin
          skipped++;
          if (skipped == SKIP) mode = MArm;
        end
      end else if (mode == MArm) begin
        if (fall) mode = MAct;
      end else begin
        if (hfall || (rise && hr)) begin
          px = lbytes / 2; odd = (lbytes % 2) == 1;
          if (px > 0 || odd) begin
            e_le = 1;
            if (px != H || odd) e_err = 1;
          end
          if (px > 0) lines++;
          lbytes = 0;
        end
        if (rise) begin
          if (lines > 0) begin
            e_fe = 1;
            if (lines != V) e_err = 1;
          end
          lines = 0; lbytes = 0; trunc = hr;
        end else if (hr && !trunc) begin
          lbytes++;
          if (lbytes % 2 == 1) m_hi = m_d1;
          else begin
            e_pv = 1;
            e_pd = {m_hi, m_d1};
            e_x  = (lbytes / 2 - 1 > 2047) ? 2047 : lbytes / 2 - 1;
            e_y  = (lines > 1023) ? 1023 : lines;
            e_fs = (lbytes == 2) && (lines == 0);
          end
        end
        if (!hr) trunc = 0;
      end
      m_vs2 = m_vs1; m_hr2 = m_hr1;
      m_vs1 = cmos_vsync; m_hr1 = cmos_href; m_d1 = cmos_data;
    end
    model_live = 1'b1;
  endtask

  initial forever begin
    @(posedge cmos_pclk);
    model_step();
  end

  // ---------------- compare + event counters ----------------
  int n_pv, n_fs, n_le, n_fe, n_ferr, n_err_le, n_err_fe, n_triple, n_x2047;

  task automatic clr();
    n_pv = 0; n_fs = 0; n_le = 0; n_fe = 0; n_ferr = 0;
    n_err_le = 0; n_err_fe = 0; n_triple = 0; n_x2047 = 0;
  endtask

  initial forever begin
    @(negedge cmos_pclk);
    if (model_live) begin
      check("pix_valid", pix_valid, e_pv);
      check("frame_start", frame_start, e_fs);
      check("line_end", line_end, e_le);
      check("frame_end", frame_end, e_fe);
      check("frame_err", frame_err, e_err);
      if (e_pv) begin
        check("pix_data", pix_data, e_pd);
        check("x_cnt", x_cnt, e_x);
        check("y_cnt", y_cnt, e_y);
      end
      if (pix_valid) n_pv++;
      if (frame_start) n_fs++;
      if (line_end) n_le++;
      if (frame_end) n_fe++;
      if (frame_err) n_ferr++;
      if (frame_err && line_end) n_err_le++;
      if (frame_err && frame_end) n_err_fe++;
      if (line_end && frame_end && frame_err) n_triple++;
      if (pix_valid && x_cnt == 11'd2047) n_x2047++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge cmos_pclk);
    #1;
  endtask

  task automatic send_line(input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      cmos_href = 1'b1;
      cmos_data = 8'($urandom);
      tick();
    end
    cmos_href = 1'b0;
    repeat (4) tick();
  endtask

  task automatic vpulse();
    cmos_vsync = 1'b1;
    repeat (4) tick();
    cmos_vsync = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame(input int nl, input int nb);
    repeat (nl) send_line(nb);
    vpulse();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix"}, pix_data, 0);
    check({tag, "_xy"}, {x_cnt, y_cnt}, 0);
    check({tag, "_flags"}, {pix_valid, frame_start, line_end, frame_end, frame_err}, 0);
  endtask

  initial begin
    camera_rst = 1'b1; reg_conf_done = 1'b0; cmos_vsync = 1'b0; cmos_href = 1'b0;
    cmos_data = 8'h00;
    clr();
    repeat (3) tick();
    camera_rst = 1'b0;
    check_zero("reset");

    // Skip: two frames dropped, following frames captured whole.
    reg_conf_done = 1'b1;
    tick();
    clr();
    frame(V, 2 * H);
    frame(V, 2 * H);
    check("skip_pv", n_pv, 0);
    for (int f = 0; f < 2; f++) begin
      clr();
      frame(V, 2 * H);
      check("cap_pv", n_pv, H * V);
      check("cap_fe", n_fe, 1);
      check("cap_fs", n_fs, 1);
      check("cap_err", n_ferr, 0);
    end

    // Packing and latency.
    clr();
    cmos_href = 1'b1; cmos_data = 8'hA1; tick();
    cmos_data = 8'hB2; tick(); check("lat_b2_early", pix_valid, 0);
    cmos_data = 8'hC3; tick();
    check("lat_b2", pix_valid, 1); check("px0", pix_data, 16'hA1B2); check("x0", x_cnt, 0);
    cmos_data = 8'hD4; tick(); check("lat_d4_early", pix_valid, 0);
    cmos_href = 1'b0; tick();
    check("lat_d4", pix_valid, 1); check("px1", pix_data, 16'hC3D4); check("x1", x_cnt, 1);
    repeat (4) tick();
    vpulse();
    check("pack_le", n_le, 1);
    check("pack_err", n_ferr, 2);

    // Reset mid-line, then skip restarts.
    for (int i = 0; i < 6; i++) begin
      cmos_href = 1'b1; cmos_data = 8'($urandom); tick();
    end
    camera_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmos_data = 8'($urandom); tick();
    end
    camera_rst = 1'b0;
    check_zero("midrst");
    clr();
    send_line(7);
    frame(V, 2 * H);
    frame(V, 2 * H);
    check("rst_skip_pv", n_pv, 0);

    // Geometry errors.
    clr();
    send_line(2 * H - 2);
    check("short_err", n_ferr, 1);
    check("short_err_le", n_err_le, 1);
    send_line(2 * H);
    clr();
    send_line(2 * H + 1);
    check("odd_pv", n_pv, H);
    check("odd_le", n_le, 1);
    check("odd_err", n_err_le, 1);
    clr();
    vpulse();
    check("short_frame_fe", n_fe, 1);
    check("short_frame_err", n_err_fe, 1);

    // Config drop mid-frame.
    send_line(2 * H);
    send_line(2 * H);
    for (int i = 0; i < 6; i++) begin
      cmos_href = 1'b1; cmos_data = 8'($urandom); tick();
    end
    reg_conf_done = 1'b0;
    cmos_data = 8'($urandom);
    tick();
    check("flush_pv", pix_valid, 0);
    check("flush_xy", {x_cnt, y_cnt}, 0);
    send_line(6);
    vpulse();
    clr();
    reg_conf_done = 1'b1;
    tick();
    frame(V, 2 * H);
    frame(V, 2 * H);
    check("reconf_skip_pv", n_pv, 0);
    clr();
    frame(V, 2 * H);
    check("reconf_cap_pv", n_pv, H * V);

    // Vsync rises during a line at x=100.
    clr();
    send_line(2 * H);
    send_line(2 * H);
    for (int i = 0; i < 200; i++) begin
      cmos_href = 1'b1; cmos_data = 8'($urandom); tick();
    end
    cmos_vsync = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmos_data = 8'($urandom); tick();
    end
    cmos_href = 1'b0;
    repeat (3) tick();
    cmos_vsync = 1'b0;
    repeat (4) tick();
    check("trunc_triple", n_triple, 1);
    check("trunc_fe", n_fe, 1);
    check("trunc_err", n_ferr, 1);
    check("trunc_le", n_le, 3);

    // x saturation on an overlong line.
    clr();
    send_line(4100);
    check("sat_pv", n_pv, 2050);
    check("sat_x2047", n_x2047, 3);
    vpulse();

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
